// File: rtl/rxe_preamble_strip_pkg.sv
// rxe_preamble_strip_pkg: shared Ethernet preamble constants and RX strip FSM encoding
package rxe_preamble_strip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    localparam logic [3:0] ETH_PRE_NIBBLE = 4'h5;
    localparam logic [3:0] ETH_SFD_NIBBLE = 4'hd;

endpackage

// File: rtl/rxe_preamble_strip.sv
// rxe_preamble_strip: validates and removes the 0x5..0x5,0xd preamble/SFD from an RX nibble stream
module rxe_preamble_strip
    import rxe_preamble_strip_pkg::*;
#(
    parameter int MIN_PRE = 6
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_v,
    input  logic [3:0] i_d,
    output logic       o_v,
    output logic [3:0] o_d,
    output logic       o_sof,
    output logic       o_err
);

    localparam logic [3:0] MIN_CNT = 4'(MIN_PRE);

    rx_state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       raw_prev, raw_prev_n;
    logic       v_n, sof_n, err_n;
    logic [3:0] d_n;

    // next state and output values for one nibble step; cnt stays non-zero across the SFD to mark the first payload nibble
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        v_n        = 1'b0;
        d_n        = 4'h0;
        sof_n      = 1'b0;
        err_n      = 1'b0;
        raw_prev_n = !i_en && i_v;
        if (!i_en) begin
            state_n = ST_IDLE;
            cnt_n   = 4'h0;
            v_n     = i_v;
            d_n     = i_d;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_v) begin
                        if (raw_prev) begin
                            state_n = ST_DROP;
                        end else if (i_d == ETH_PRE_NIBBLE) begin
                            state_n = ST_PRE;
                            cnt_n   = 4'h1;
                        end else begin
                            state_n = ST_DROP;
                            err_n   = 1'b1;
                        end
                    end
                end
                ST_PRE: begin
                    if (!i_v) begin
                        state_n = ST_IDLE;
                        cnt_n   = 4'h0;
                        err_n   = 1'b1;
                    end else if (i_d == ETH_PRE_NIBBLE) begin
                        cnt_n = (cnt == 4'hf) ? cnt : cnt + 4'h1;
                    end else if (i_d == ETH_SFD_NIBBLE && cnt >= MIN_CNT) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_DROP;
                        cnt_n   = 4'h0;
                        err_n   = 1'b1;
                    end
                end
                ST_DATA: begin
                    cnt_n = 4'h0;
                    if (i_v) begin
                        v_n   = 1'b1;
                        d_n   = i_d;
                        sof_n = cnt != 4'h0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!i_v) state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'h0;
                end
            endcase
        end
    end

    // state and output registers advance only on nibble-rate enable; reset wins regardless of i_ce
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'h0;
            raw_prev <= 1'b0;
            o_v      <= 1'b0;
            o_d      <= 4'h0;
            o_sof    <= 1'b0;
            o_err    <= 1'b0;
        end else if (i_ce) begin
            state    <= state_n;
            cnt      <= cnt_n;
            raw_prev <= raw_prev_n;
            o_v      <= v_n;
            o_d      <= d_n;
            o_sof    <= sof_n;
            o_err    <= err_n;
        end
    end

endmodule

// File: tb/tb_rxe_preamble_strip.sv
// tb_rxe_preamble_strip: frame-level reference model checks for rxe_preamble_strip
module tb_rxe_preamble_strip;

    localparam int MIN_PRE = 6;

    typedef logic [3:0] nib_q [$];
    typedef logic [6:0] exp_q [$];
    typedef struct packed {
        logic       en;
        logic       v;
        logic [3:0] d;
        logic [6:0] e;
    } step_t;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_ce = 1'b0;
    logic       i_en = 1'b0;
    logic       i_v = 1'b0;
    logic [3:0] i_d = 4'h0;
    logic       o_v;
    logic [3:0] o_d;
    logic       o_sof;
    logic       o_err;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [6:0] last_exp = 7'h0;

    rxe_preamble_strip #(.MIN_PRE(MIN_PRE)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_en(i_en),
        .i_v(i_v), .i_d(i_d), .o_v(o_v), .o_d(o_d), .o_sof(o_sof), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [6:0] obs();
        return {o_v, o_d, o_sof, o_err};
    endfunction

    function automatic logic [6:0] ex(input logic v, input logic [3:0] d, input logic sof, input logic err);
        return {v, d, sof, err};
    endfunction

    function automatic step_t mk(input logic en, input logic v, input logic [3:0] d, input logic [6:0] e);
        return '{en: en, v: v, d: d, e: e};
    endfunction

    // Frame-level model: output after step i for a frame f followed by one gap step (index f.size()).
    function automatic exp_q model_frame(input nib_q f);
        exp_q e;
        int   l = f.size();
        int   p = 0;
        while (p < l && f[p] == 4'h5) p++;
        for (int i = 0; i <= l; i++) e.push_back(7'h0);
        if (l == 0) begin
        end else if (p == 0) begin
            e[0] = 7'h01;
        end else if (p == l) begin
            e[l] = 7'h01;
        end else if (f[p] == 4'hd && p >= MIN_PRE) begin
            for (int i = p + 1; i < l; i++) e[i] = {1'b1, f[i], (i == p + 1), 1'b0};
        end else begin
            e[p] = 7'h01;
        end
        return e;
    endfunction

    function automatic nib_q good_frame(input int npre, input int npay);
        nib_q f;
        for (int i = 0; i < npre; i++) f.push_back(4'h5);
        f.push_back(4'hd);
        for (int i = 0; i < npay; i++) f.push_back(4'($urandom_range(0, 15)));
        return f;
    endfunction

    task automatic drive_step(input logic en, input logic v, input logic [3:0] d);
        i_en = en;
        i_v  = v;
        i_d  = d;
        i_ce = 1'b1;
        @(posedge i_clk);
        #1;
        i_ce = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_ce = 1'b0;
            i_en = 1'($urandom_range(0, 1));
            i_v  = 1'b1;
            i_d  = 4'($urandom_range(0, 15));
            @(posedge i_clk);
            #1;
            n_checks++;
            if (obs() !== 7'h0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", k, obs(), 7'h0);
            end
        end
        i_reset_n = 1'b1;
        drive_step(1'b1, 1'b0, 4'h0);
        last_exp = 7'h0;
    endtask

    task automatic test_good_frame();
        nib_q f;
        exp_q e;
        for (int i = 0; i < 15; i++) f.push_back(4'h5);
        f.push_back(4'hd);
        for (int i = 1; i <= 8; i++) f.push_back(4'(i));
        e = model_frame(f);
        for (int i = 0; i <= f.size(); i++) begin
            drive_step(1'b1, i < f.size(), i < f.size() ? f[i] : 4'h0);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL good_frame step %0d: got %h expected %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_short_preamble();
        nib_q f;
        exp_q e;
        f = good_frame(5, 6);
        for (int r = 0; r < 2; r++) begin
            e = model_frame(f);
            for (int i = 0; i <= f.size(); i++) begin
                drive_step(1'b1, i < f.size(), i < f.size() ? f[i] : 4'h0);
                n_checks++;
                if (obs() !== e[i]) begin
                    n_fail++;
                    $display("FAIL short_pre pass %0d step %0d: got %h expected %h", r, i, obs(), e[i]);
                end
            end
            f = good_frame(MIN_PRE, 5);
        end
    endtask

    task automatic test_bad_nibble();
        nib_q f;
        exp_q e;
        for (int i = 0; i < 7; i++) f.push_back(4'h5);
        f.push_back(4'h3);
        f.push_back(4'h5);
        f.push_back(4'hd);
        f.push_back(4'h1);
        e = model_frame(f);
        for (int i = 0; i <= f.size(); i++) begin
            drive_step(1'b1, i < f.size(), i < f.size() ? f[i] : 4'h0);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL bad_nibble step %0d: got %h expected %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_passthrough();
        logic [3:0] ds [5] = '{4'h5, 4'h5, 4'hd, 4'ha, 4'hb};
        logic       v;
        logic [3:0] d;
        for (int i = 0; i < 26; i++) begin
            v = i < 5 ? 1'b1 : i == 5 ? 1'b0 : 1'($urandom_range(0, 1));
            d = i < 5 ? ds[i] : 4'($urandom_range(0, 15));
            drive_step(1'b0, v, d);
            n_checks++;
            if (obs() !== ex(v, d, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL passthrough step %0d: got %h expected %h", i, obs(), ex(v, d, 1'b0, 1'b0));
            end
        end
        drive_step(1'b1, 1'b0, 4'h0);
    endtask

    task automatic test_enable_switch();
        step_t s [$];
        nib_q  f;
        exp_q  e;
        s.push_back(mk(1'b0, 1'b1, 4'h5, ex(1'b1, 4'h5, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b1, 4'h5, ex(1'b1, 4'h5, 1'b0, 1'b0)));
        s.push_back(mk(1'b1, 1'b1, 4'h5, 7'h0));
        s.push_back(mk(1'b1, 1'b1, 4'hd, 7'h0));
        s.push_back(mk(1'b1, 1'b1, 4'ha, 7'h0));
        s.push_back(mk(1'b1, 1'b1, 4'h7, 7'h0));
        s.push_back(mk(1'b1, 1'b0, 4'h0, 7'h0));
        for (int i = 0; i < MIN_PRE; i++) s.push_back(mk(1'b1, 1'b1, 4'h5, 7'h0));
        s.push_back(mk(1'b1, 1'b1, 4'hd, 7'h0));
        s.push_back(mk(1'b1, 1'b1, 4'h1, ex(1'b1, 4'h1, 1'b1, 1'b0)));
        s.push_back(mk(1'b0, 1'b1, 4'h2, ex(1'b1, 4'h2, 1'b0, 1'b0)));
        s.push_back(mk(1'b0, 1'b0, 4'h3, ex(1'b0, 4'h3, 1'b0, 1'b0)));
        s.push_back(mk(1'b1, 1'b0, 4'h0, 7'h0));
        foreach (s[i]) begin
            drive_step(s[i].en, s[i].v, s[i].d);
            n_checks++;
            if (obs() !== s[i].e) begin
                n_fail++;
                $display("FAIL enable_switch step %0d: got %h expected %h", i, obs(), s[i].e);
            end
        end
        f = good_frame(MIN_PRE + 1, 6);
        e = model_frame(f);
        for (int i = 0; i <= f.size(); i++) begin
            if (i == MIN_PRE + 4) begin
                for (int k = 0; k < 3; k++) begin
                    i_ce = 1'b0;
                    i_en = 1'($urandom_range(0, 1));
                    i_v  = 1'($urandom_range(0, 1));
                    i_d  = 4'($urandom_range(0, 15));
                    @(posedge i_clk);
                    #1;
                    n_checks++;
                    if (obs() !== e[i - 1]) begin
                        n_fail++;
                        $display("FAIL ce_hold cycle %0d: got %h expected %h", k, obs(), e[i - 1]);
                    end
                end
            end
            drive_step(1'b1, i < f.size(), i < f.size() ? f[i] : 4'h0);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL ce_frame step %0d: got %h expected %h", i, obs(), e[i]);
            end
        end
    endtask

    task automatic test_reset_in_data();
        nib_q f;
        exp_q e;
        f = good_frame(MIN_PRE, 4);
        e = model_frame(f);
        for (int i = 0; i < MIN_PRE + 3; i++) begin
            drive_step(1'b1, 1'b1, f[i]);
            n_checks++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL reset_data step %0d: got %h expected %h", i, obs(), e[i]);
            end
        end
        i_reset_n = 1'b0;
        i_ce = 1'b0;
        i_d  = 4'h9;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        n_checks++;
        if (obs() !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_data after reset: got %h expected %h", obs(), 7'h0);
        end
        drive_step(1'b1, 1'b1, 4'h7);
        n_checks++;
        if (obs() !== 7'h01) begin
            n_fail++;
            $display("FAIL reset_data idle err: got %h expected %h", obs(), 7'h01);
        end
        drive_step(1'b1, 1'b0, 4'h0);
        n_checks++;
        if (obs() !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_data gap: got %h expected %h", obs(), 7'h0);
        end
        last_exp = 7'h0;
    endtask

    task automatic test_random_frames();
        nib_q f;
        exp_q e;
        int   p, kind;
        for (int n = 0; n < 40; n++) begin
            f.delete();
            p    = $urandom_range(0, 18);
            kind = $urandom_range(0, 3);
            for (int i = 0; i < p; i++) f.push_back(4'h5);
            if (kind <= 1) begin
                f.push_back(4'hd);
                for (int i = 0; i < int'($urandom_range(0, 10)); i++) f.push_back(4'($urandom_range(0, 15)));
            end else if (kind == 2) begin
                f.push_back($urandom_range(0, 1) ? 4'h0 : 4'hf);
                for (int i = 0; i < int'($urandom_range(0, 4)); i++) f.push_back(4'($urandom_range(0, 15)));
            end
            e = model_frame(f);
            for (int i = 0; i <= f.size(); i++) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    i_ce = 1'b0;
                    i_en = 1'($urandom_range(0, 1));
                    i_v  = 1'($urandom_range(0, 1));
                    i_d  = 4'($urandom_range(0, 15));
                    @(posedge i_clk);
                    #1;
                    n_checks++;
                    if (obs() !== last_exp) begin
                        n_fail++;
                        $display("FAIL random hold frame %0d step %0d: got %h expected %h", n, i, obs(), last_exp);
                    end
                end
                drive_step(1'b1, i < f.size(), i < f.size() ? f[i] : 4'($urandom_range(0, 15)));
                n_checks++;
                if (obs() !== e[i]) begin
                    n_fail++;
                    $display("FAIL random frame %0d step %0d: got %h expected %h", n, i, obs(), e[i]);
                end
                last_exp = e[i];
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_preamble();
        test_bad_nibble();
        test_passthrough();
        test_enable_switch();
        test_reset_in_data();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
